// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between the multicycle CPU
// (instruction fetch / load / store) and an external requester (program
// loader / debug port). In IDLE the pending requests are sampled and one is
// granted. Ties are broken round-robin, and the CPU wins the first tie after
// reset. The winner's command is latched and the memory is driven for
// MEM_LAT cycles. The read data is captured in the last cycle. A one-cycle
// done pulse follows, and then the port returns to IDLE.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata    CPU request; hold req until cpu_done
//   cpu_rdata, cpu_done      CPU read data (held) and completion pulse
//   cpu_stall                holds the CPU control FSM while its access pends
//   ext_req/we/addr/wdata    external request, same protocol as the CPU
//   ext_rdata, ext_done      external read data (held) and completion pulse
//   mem_en/we/addr/wdata     memory command, stable for the whole access
//   mem_rdata                memory read data, valid in the last access cycle
//   owner                    00 none, 01 CPU, 10 external
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1    // legal 1..7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_EXT  = 2'b10;

  // The counter counts the remaining access cycles. It reaches 0 in the last cycle.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_owner;
  logic              r_last_ext;   // 1: the external requester won the last grant
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ext_rdata;
  logic              w_grant_cpu;
  logic              w_grant_ext;

  // The CPU takes the port when it is alone or when the external side won last.
  assign w_grant_cpu = cpu_req & (~ext_req | r_last_ext);
  assign w_grant_ext = ext_req & ~w_grant_cpu;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential logic uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the order of the statements.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default assignment comes first, so no path through the case
    // leaves the signal unassigned. An unassigned path would infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (cpu_req || ext_req) w_next_state = S_ACCESS;
      S_ACCESS: if (r_cnt == 3'd0)      w_next_state = S_DONE;
      S_DONE:                           w_next_state = S_IDLE;
      default:                          w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state. An async reset of the state drops
  // mem_en and mem_we at once and also cancels any pending done pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    cpu_done = 1'b0;
    ext_done = 1'b0;
    case (r_state)
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_we;
      end
      S_DONE: begin
        cpu_done = (r_owner == OWN_CPU);
        ext_done = (r_owner == OWN_EXT);
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign owner     = r_owner;
  assign cpu_rdata = r_cpu_rdata;
  assign ext_rdata = r_ext_rdata;
  // The stall is released in the done cycle, so the CPU FSM advances on the
  // edge that ends the access.
  assign cpu_stall = cpu_req & ~cpu_done;

  // ---------------------------------------------------------------------------
  // Command latch, access counter, read-data capture, arbitration history
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the datapath registers are reset as well. Their values appear
      // directly on the memory and requester ports, which must read 0 out of reset.
      r_cnt       <= 3'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_owner     <= OWN_NONE;
      r_last_ext  <= 1'b1;
      r_cpu_rdata <= '0;
      r_ext_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_cpu) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_owner <= OWN_CPU;
            r_cnt   <= LAT_M1;
          end else if (w_grant_ext) begin
            r_we    <= ext_we;
            r_addr  <= ext_addr;
            r_wdata <= ext_wdata;
            r_owner <= OWN_EXT;
            r_cnt   <= LAT_M1;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 3'd0) begin
            // A write leaves the owner's read data untouched.
            if (!r_we) begin
              if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
              if (r_owner == OWN_EXT) r_ext_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_DONE: begin
          r_last_ext <= (r_owner == OWN_EXT);
          r_owner    <= OWN_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two random requesters follow the req/done protocol. Each one pushes the
// command it issues into its own scoreboard queue. After it is granted, a
// requester scrambles its inputs to show that the latched command is used.
// A monitor on the falling edge tracks each access at the transaction level:
// - the grant winner follows the round-robin rule, and the CPU wins the first tie
// - MEM_LAT cycles of stable command
// - a done pulse for the right owner
// - the read data comes from a behavioural memory
// A directed section at the end covers the command hold and an asynchronous
// reset during a write.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, ext_done, mem_en, mem_we;
  logic [1:0]  owner;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural memory. An untouched location reads as a hash of its address.
  // Data appears only in the last access cycle, and the other cycles return junk.
  // ---------------------------------------------------------------------------
  logic [15:0] store [logic [15:0]];
  int          en_cnt = 0;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (store.exists(a)) return store[a];
    return (a * 16'd40503) ^ 16'h1357;
  endfunction

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we && en_cnt == LAT - 1) store[mem_addr] = mem_wdata;
      en_cnt = en_cnt + 1;
    end else begin
      en_cnt = 0;
    end
  end

  always @(negedge CLK)
    mem_rdata = (mem_en && en_cnt == LAT - 1) ? mem_val(mem_addr) : (16'hDEAD ^ 16'(en_cnt));

  // ---------------------------------------------------------------------------
  // Scoreboard queues and requester drivers (who: 0 = CPU, 1 = external)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t q_cpu[$];
  txn_t q_ext[$];

  function automatic logic [1:0] code(input int who);
    return (who == 0) ? 2'b01 : (who == 1) ? 2'b10 : 2'b00;
  endfunction

  task automatic drive(input int who, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    if (who == 0) begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end else begin
      ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
    end
  endtask

  task automatic run_req(input int who, input int n);
    txn_t t;
    int   gap;
    int   cyc;
    for (int i = 0; i < n; i++) begin
      gap = (i == 0) ? 0 : $urandom_range(0, 3);
      if (gap > 0) begin
        drive(who, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (gap) begin @(posedge CLK); #1; end
      end
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = 16'($urandom_range(0, 15));
      t.wdata = 16'($urandom);
      if (who == 0) q_cpu.push_back(t); else q_ext.push_back(t);
      drive(who, 1'b1, t.we, t.addr, t.wdata);
      cyc = 0;
      forever begin
        @(negedge CLK);
        if ((who == 0) ? cpu_done : ext_done) break;
        cyc++;
        if (cyc > 60) begin
          checks++;
          errors++;
          $display("FAIL req%0d_done_wait: waited %0d cycles, limit 60", who, cyc);
          break;
        end
        @(posedge CLK); #1;
        if (owner == code(who))
          drive(who, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
      @(posedge CLK); #1;
    end
    drive(who, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: transaction-level tracking of each access
  // ---------------------------------------------------------------------------
  typedef enum int {PH_IDLE, PH_ACC, PH_DONE, PH_POST} phase_t;

  logic        mon_en   = 1'b0;
  phase_t      phase    = PH_IDLE;
  int          cur      = -1;
  int          acc      = 0;
  int          last_w   = 1;          // external side counts as the last winner out of reset
  logic        prev_cpu = 1'b0;
  logic        prev_ext = 1'b0;
  logic [15:0] last_rd [2] = '{16'h0, 16'h0};
  txn_t        t_cur;

  always @(negedge CLK) begin : monitor
    int          exp_w;
    logic        in_done;
    logic [1:0]  exp_dn;
    logic [15:0] exp_rd;
    if (mon_en) begin
      in_done = (phase == PH_DONE);
      exp_dn  = in_done ? ((cur == 0) ? 2'b10 : 2'b01) : 2'b00;
      check("done_pulse", 32'({cpu_done, ext_done}), 32'(exp_dn));
      check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~(in_done && cur == 0)));

      if (phase == PH_IDLE) begin
        if (prev_cpu && prev_ext) exp_w = (last_w == 1) ? 0 : 1;
        else if (prev_cpu)        exp_w = 0;
        else if (prev_ext)        exp_w = 1;
        else                      exp_w = -1;
        check("grant_owner", 32'(owner), 32'(code(exp_w)));
        if (exp_w < 0) begin
          check("idle_mem_en", 32'(mem_en), 32'(0));
        end else begin
          check("sb_queue_nonempty",
                32'((exp_w == 0) ? (q_cpu.size() != 0) : (q_ext.size() != 0)), 32'(1));
          if (exp_w == 0 && q_cpu.size() != 0) t_cur = q_cpu.pop_front();
          if (exp_w == 1 && q_ext.size() != 0) t_cur = q_ext.pop_front();
          cur   = exp_w;
          acc   = 0;
          phase = PH_ACC;
        end
      end else if (phase == PH_DONE) begin
        check("done_owner", 32'(owner), 32'(code(cur)));
        check("done_mem_en", 32'(mem_en), 32'(0));
        exp_rd = t_cur.we ? last_rd[cur] : mem_val(t_cur.addr);
        check(cur == 0 ? "cpu_rdata" : "ext_rdata",
              32'((cur == 0) ? cpu_rdata : ext_rdata), 32'(exp_rd));
        check("other_rdata_held",
              32'((cur == 0) ? ext_rdata : cpu_rdata), 32'(last_rd[1 - cur]));
        last_rd[cur] = exp_rd;
        last_w       = cur;
        phase        = PH_POST;
      end else if (phase == PH_POST) begin
        check("post_owner", 32'(owner), 32'(0));
        check("post_mem_en", 32'(mem_en), 32'(0));
        phase = PH_IDLE;
      end

      if (phase == PH_ACC) begin
        check("acc_owner", 32'(owner), 32'(code(cur)));
        check("acc_mem_en", 32'(mem_en), 32'(1));
        check("acc_mem_we", 32'(mem_we), 32'(t_cur.we));
        check("acc_mem_addr", 32'(mem_addr), 32'(t_cur.addr));
        check("acc_mem_wdata", 32'(mem_wdata), 32'(t_cur.wdata));
        acc++;
        if (acc == LAT) phase = PH_DONE;
      end
    end
    prev_cpu = cpu_req;
    prev_ext = ext_req;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_en"},    32'(mem_en),    32'(0));
    check({tag, "_mem_we"},    32'(mem_we),    32'(0));
    check({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    check({tag, "_owner"},     32'(owner),     32'(0));
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(0));
    check({tag, "_ext_rdata"}, 32'(ext_rdata), 32'(0));
    check({tag, "_cpu_done"},  32'(cpu_done),  32'(0));
    check({tag, "_ext_done"},  32'(ext_done),  32'(0));
    check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'(cpu_req));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    RST = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    #3;
    check_reset_outputs("rst0");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    mon_en = 1'b1;

    // Both sides start together, so the CPU must win the first tie.
    fork
      run_req(0, 40);
      run_req(1, 40);
    join
    repeat (4) @(negedge CLK);
    mon_en = 1'b0;

    // Directed: the latched address holds, then an async reset hits mid-write.
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, 16'h0030, 16'h1234);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!mem_en && n < 10);
    check("dir_first_access", 32'(mem_en), 32'(1));
    check("dir_mem_addr", 32'(mem_addr), 32'(16'h0030));
    check("dir_mem_we", 32'(mem_we), 32'(1));
    @(posedge CLK); #1;
    cpu_addr = 16'h0040;
    @(negedge CLK);
    check("dir_addr_hold", 32'(mem_addr), 32'(16'h0030));
    check("dir_wdata_hold", 32'(mem_wdata), 32'(16'h1234));
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge CLK); #1;
    check("rst_hold_owner", 32'(owner), 32'(0));
    check("rst_hold_cpu_done", 32'(cpu_done), 32'(0));
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_grant", 32'(owner), 32'(2'b01));
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!cpu_done && n < 20);
    check("post_rst_latency", 32'(n), 32'(LAT + 1));
    check("post_rst_mem_addr", 32'(mem_addr), 32'(16'h0040));
    check("post_rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    check("post_rst_stall", 32'(cpu_stall), 32'(0));
    @(posedge CLK); #1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates and sequences the single unified memory port between two requesters: the multicycle CPU control/datapath (instruction fetch and load/store) and an external requester (program loader / debug port). It latches the winning request, drives the memory for a fixed number of cycles, returns read data and a one-cycle completion pulse, and stalls the CPU control state machine while its access is pending. It sits between the control unit's MemRead/MemWrite/IorD-selected address path and the memory block.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data word width
- MEM_LAT, 1, memory access cycles per transfer (legal 1..7)

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request (MemRead|MemWrite)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address (after IorD mux)
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data to CPU
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  hold control FSM in current state
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external requester, same meaning as CPU
- ext_rdata  out  DATA_W  registered read data to external requester
- ext_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last access cycle
- owner  out  2  00 none, 01 CPU, 10 external

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: sample cpu_req/ext_req. None: stay. One: grant it. Both: grant the requester that did not win the previous grant (round-robin); last_winner resets to external, so CPU wins the first tie.
- Grant: latch we, addr, wdata and owner; load counter with MEM_LAT-1; go ACCESS.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latches (stable all cycles). Counter decrements each cycle; at 0 capture mem_rdata into the owner's rdata register (reads only; writes leave it unchanged) and go DONE.
- DONE: assert owner's done for exactly one cycle; mem_en=0; update last_winner; owner cleared to 00 on exit; go IDLE. Requests are not sampled in DONE.
- Requester protocol: hold req high until done is seen; deassert req by the edge ending the done cycle. A req still high in the following IDLE is a new access.
- cpu_stall = cpu_req & ~cpu_done (combinational); low when cpu_req low.
- Non-owner inputs are ignored during ACCESS/DONE; changes to owner's inputs after grant have no effect.
- rdata registers hold value until the next read by that requester.

## Timing
- Reset (async, immediate): state IDLE, owner 00, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, ext_rdata 0, cpu_done 0, ext_done 0, counter 0, last_winner external. cpu_stall follows cpu_req.
- Reset mid-ACCESS: transfer aborted, mem_we drops asynchronously, no done pulse issued.
- Latency: req high before edge k (in IDLE) → ACCESS cycles k+1 .. k+MEM_LAT → done high in cycle k+MEM_LAT+1 → IDLE at k+MEM_LAT+2. Throughput: one access per MEM_LAT+2 cycles.
- Back-to-back alternating: with both reqs held, grants alternate CPU, ext, CPU, …; neither starves beyond one access.
- rdata valid in the same cycle as done and thereafter.

## Test plan
- Reset: assert RST mid-run with cpu_req=1 → all outputs 0 immediately, cpu_stall=1, no cpu_done; after release CPU is granted on next edge.
- CPU read, MEM_LAT=1: cpu_req=1, addr=0x0010, mem returns 0xBEEF → mem_en one cycle with mem_addr=0x0010, cpu_done next cycle, cpu_rdata=0xBEEF, cpu_stall high 2 cycles.
- CPU write, MEM_LAT=3: addr=0x0020, wdata=0x1234 → mem_we/mem_en high 3 cycles with stable addr/data, cpu_done in cycle 4, cpu_rdata unchanged.
- Simultaneous requests held: first grant CPU, second ext, third CPU; owner sequence 01,00,...,10,...; ext_rdata/cpu_rdata each match their own addresses.
- ext access in progress, cpu_req rises mid-ACCESS → CPU waits, cpu_stall high throughout, CPU granted in IDLE after ext_done.
- Requester changes cpu_addr 0x0030→0x0040 during ACCESS → mem_addr stays 0x0030.
